scr1_sha256_msg_sched: RTL and testbench

SHA-256 message-schedule stage that sits directly downstream of the scr1_accel data register file and upstream of the compression round engine. It captures one 512-bit message block as sixteen 32-bit words written over the accelerator's register-write path. On start, it streams the 64 schedule words W[0..63] to the round engine, one word per accepted handshake. Expansion uses a 16-word sliding window, so no 64-entry storage is needed.

---
 rtl/scr1_sha256_msg_sched.sv | 126 ++++++++++++
 tb/tb_scr1_sha256_msg_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_sha256_msg_sched.sv
// SHA-256 message schedule: captures a 16-word block, then streams W[0..63]
// through a 16-word sliding window with a ready/valid handshake.
module scr1_sha256_msg_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic        abort,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_idx,
  output logic        w_last,
  output logic        busy,
  output logic        done,
  output logic        wr_drop
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_WORDS = 16;
  localparam int unsigned T_W     = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   win_q [N_WORDS];
  logic [T_W-1:0]      t_q, t_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                shift_c;
  logic [WORD_W-1:0]   next_word_c;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return WORD_W'((x >> n) | (x << (WORD_W - n)));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Next-state and control decode; abort wins over a simultaneous handshake
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    last_d      = last_q;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    shift_c     = 1'b0;
    next_word_c = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          t_d     = '0;
          last_d  = 1'b0;
        end
      end
      RUN: begin
        drop_d = wr_en;
        if (abort) begin
          state_d = IDLE;
          t_d     = '0;
          last_d  = 1'b0;
        end else if (w_ready) begin
          shift_c = 1'b1;
          t_d     = T_W'(t_q + T_W'(1));
          last_d  = (t_q == T_W'(62));
          if (t_q == T_W'(63)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      last_q  <= last_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Window: register-file writes in IDLE, shift-and-expand on each handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WORDS; i++) win_q[i] <= '0;
    end else if (state_q == IDLE) begin
      if (wr_en) win_q[wr_idx] <= wr_data;
    end else if (shift_c) begin
      for (int i = 0; i < N_WORDS - 1; i++) win_q[i] <= win_q[i+1];
      win_q[N_WORDS-1] <= next_word_c;
    end
  end

  assign busy    = (state_q == RUN);
  assign w_valid = (state_q == RUN);
  assign w_data  = win_q[0];
  assign w_idx   = t_q;
  assign w_last  = last_q;
  assign done    = done_q;
  assign wr_drop = drop_q;

endmodule

// File: tb/tb_scr1_sha256_msg_sched.sv
// Self-checking bench for scr1_sha256_msg_sched against a direct
// 64-entry SHA-256 schedule model.
module tb_scr1_sha256_msg_sched;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  logic        start;
  logic        abort;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        busy;
  logic        done;
  logic        wr_drop;

  scr1_sha256_msg_sched dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .start(start), .abort(abort), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_idx(w_idx), .w_last(w_last), .busy(busy), .done(done),
    .wr_drop(wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [31:0] w;
  } vec_t;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] cap   [64];
  int          n_cmp;
  int          n_bad;
  int          last_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (time %0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: the textbook 64-entry recurrence
  task automatic compute_model();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[t];
      else exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                    + exp_w[t-7]
                    + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                    + exp_w[t-16];
    end
  endtask

  task automatic load_block();
    for (int i = 15; i >= 0; i--) begin
      wr_en = 1'b1; wr_idx = 4'(i); wr_data = blk[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic abc_block();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  // Starts a run at the current negedge and follows it to done (or abort/reset).
  // Ends on the negedge of the done cycle for a complete run.
  task automatic run_block(input int stall_t, input int stall_n, input int abort_t,
                           input int wr_t, input int start_t, input int rst_t,
                           input bit rand_rdy, input bit chk, input bit wr15,
                           input logic [31:0] new15);
    int t, stalls, drops, budget;
    bit rdy, wr_done, st_done;
    t = 0; stalls = 0; drops = 0; budget = 0; wr_done = 0; st_done = 0;
    last_cyc = 0;
    start = 1'b1;
    if (wr15) begin wr_en = 1'b1; wr_idx = 4'd15; wr_data = new15; end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    while (t < 64) begin
      if (budget++ > 500) begin
        check("run_timeout", 64'(t), 64'd64);
        return;
      end
      if (wr_drop) drops++;
      check("w_valid", w_valid, 1);
      check("busy", busy, 1);
      check("w_idx", w_idx, 64'(t));
      check("w_last", w_last, (t == 63) ? 1 : 0);
      check("done_low", done, 0);
      if (chk) check("w_data", w_data, exp_w[t]);
      cap[t] = w_data;
      last_cyc++;
      start = 1'b0; wr_en = 1'b0; abort = 1'b0;
      rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (t == stall_t && stalls < stall_n) begin rdy = 1'b0; stalls++; end
      if (t == wr_t && !wr_done) begin
        wr_en = 1'b1; wr_idx = 4'd3; wr_data = 32'hDEADBEEF; wr_done = 1;
      end
      if (t == start_t && !st_done) begin start = 1'b1; st_done = 1; end
      if (t == abort_t) begin
        abort = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", w_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        check("abort_done2", done, 0);
        return;
      end
      if (t == rst_t) begin
        rst_n = 1'b0;
        #1;
        check("rst_outs", {w_valid, w_last, busy, done, wr_drop, w_idx, w_data}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      w_ready = rdy;
      @(negedge clk);
      if (rdy) t++;
    end
    if (wr_drop) drops++;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", w_valid, 0);
    check("wr_drop_cnt", 64'(drops), (wr_t >= 0) ? 64'd1 : 64'd0);
  endtask

  vec_t abc_vec [7];

  initial begin
    logic [31:0] new15;
    n_cmp = 0; n_bad = 0;
    abc_vec[0] = '{0,  32'h61626380};
    abc_vec[1] = '{1,  32'h00000000};
    abc_vec[2] = '{5,  32'h00000000};
    abc_vec[3] = '{14, 32'h00000000};
    abc_vec[4] = '{15, 32'h00000018};
    abc_vec[5] = '{16, 32'h61626380};
    abc_vec[6] = '{17, 32'h000F0000};

    rst_n = 1'b0; wr_en = 1'b0; wr_idx = 4'd0; wr_data = 32'h0;
    start = 1'b0; abort = 1'b0; w_ready = 1'b0;
    #12;
    check("reset_outs", {w_valid, w_last, busy, done, wr_drop, w_idx, w_data}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc" block, full speed, compared to model and fixed table
    abc_block(); compute_model(); load_block();
    run_block(-1, 0, -1, -1, -1, -1, 0, 1, 0, 32'h0);
    for (int i = 0; i < 7; i++) check("abc_table", cap[abc_vec[i].t], abc_vec[i].w);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // Backpressure: three stall cycles at t = 5
    load_block();
    run_block(5, 3, -1, -1, -1, -1, 0, 1, 0, 32'h0);
    check("stall_total_cycles", 64'(last_cyc), 64'd67);
    @(negedge clk);

    // Abort at t = 20, then rewrite and run a fresh random block
    load_block();
    run_block(-1, 0, 20, -1, -1, -1, 0, 1, 0, 32'h0);
    rand_block(); compute_model(); load_block();
    run_block(-1, 0, -1, -1, -1, -1, 1, 1, 0, 32'h0);
    @(negedge clk);

    // Write during RUN at t = 10 plus an ignored start at t = 40
    abc_block(); compute_model(); load_block();
    run_block(-1, 0, -1, 10, 40, -1, 0, 1, 0, 32'h0);
    @(negedge clk);

    // Start/write collision on W15, random backpressure
    rand_block(); load_block();
    new15 = $urandom;
    blk[15] = new15; compute_model();
    run_block(-1, 0, -1, -1, -1, -1, 1, 1, 1, new15);
    check("collision_w15", cap[15], new15);

    // Back-to-back: restart in the done cycle (window content unspecified)
    run_block(-1, 0, -1, -1, -1, -1, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("b2b_done_clear", done, 0);

    // Random blocks with random backpressure
    for (int k = 0; k < 4; k++) begin
      rand_block(); compute_model(); load_block();
      run_block(-1, 0, -1, -1, -1, -1, 1, 1, 0, 32'h0);
      @(negedge clk);
    end

    // Reset at t = 30; window must be cleared afterwards
    rand_block(); compute_model(); load_block();
    run_block(-1, 0, -1, -1, -1, 30, 0, 1, 0, 32'h0);
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_data", w_data, 0);
    check("post_rst_done", done, 0);
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    compute_model();
    run_block(-1, 0, -1, -1, -1, -1, 0, 1, 0, 32'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
